// File: rtl/li_sequencer.sv
// rtl/li_sequencer.sv - LI16/LHI/LLI sequencer driving the load-immediate helper and the shared register-file write port.
module li_sequencer #(
    parameter int REG_AW       = 3,
    parameter int MAX_STALL    = 4,
    parameter bit SKIP_ZERO_LO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_mode,
    input  logic [REG_AW-1:0] req_rt,
    input  logic [15:0]       req_imm16,
    input  logic              wb_busy,
    output logic              wb_hold,
    output logic              is_lhi,
    output logic              is_lli,
    output logic [7:0]        imm8,
    output logic [REG_AW-1:0] rf_rd_addr,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic              busy,
    output logic              done
);

    localparam int SW = $clog2(MAX_STALL + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

    localparam logic [1:0] MODE_LI16 = 2'b00;
    localparam logic [1:0] MODE_LHI  = 2'b01;
    localparam logic [1:0] MODE_LLI  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       stall_q, stall_d;
    logic                done_q, done_d;
    logic [REG_AW-1:0]   rt_q, rt_d;
    logic [15:0]         imm_q, imm_d;
    logic [1:0]          mode_q, mode_d;

    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        done_d     = 1'b0;
        rt_d       = rt_q;
        imm_d      = imm_q;
        mode_d     = mode_q;
        req_ready  = 1'b0;
        rf_we      = 1'b0;
        is_lhi     = 1'b0;
        is_lli     = 1'b0;
        imm8       = 8'h00;
        rf_rd_addr = '0;
        rf_waddr   = '0;
        wb_hold    = 1'b0;

        // Everything stays quiet while reset is held so a dropped request never writes.
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    req_ready = 1'b1;
                    stall_d   = '0;
                    if (req_valid) begin
                        rt_d   = req_rt;
                        imm_d  = req_imm16;
                        mode_d = req_mode;
                        case (req_mode)
                            MODE_LI16, MODE_LHI: state_d = HI;
                            MODE_LLI:            state_d = LO;
                            default:             done_d  = 1'b1;
                        endcase
                    end
                end
                HI, LO: begin
                    rf_rd_addr = rt_q;
                    rf_waddr   = rt_q;
                    wb_hold    = (stall_q == STALL_MAX);
                    if (wb_busy) begin
                        if (stall_q != STALL_MAX) stall_d = stall_q + SW'(1);
                    end else begin
                        stall_d = '0;
                        rf_we   = 1'b1;
                        if (state_q == HI) begin
                            is_lhi = 1'b1;
                            imm8   = imm_q[15:8];
                            if (mode_q == MODE_LI16 && !(SKIP_ZERO_LO && imm_q[7:0] == 8'h00)) begin
                                state_d = LO;
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            is_lli  = 1'b1;
                            imm8    = imm_q[7:0];
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stall_q <= '0;
            done_q  <= 1'b0;
            rt_q    <= '0;
            imm_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            done_q  <= done_d;
            rt_q    <= rt_d;
            imm_q   <= imm_d;
            mode_q  <= mode_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_li_sequencer.sv
// tb/tb_li_sequencer.sv - directed bench for li_sequencer with a register-file and helper model.
module tb_li_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [1:0]  req_mode;
    logic [2:0]  req_rt;
    logic [15:0] req_imm16;
    logic        wb_busy;

    logic        req_ready, wb_hold, is_lhi, is_lli, rf_we, busy, done;
    logic [7:0]  imm8;
    logic [2:0]  rf_rd_addr, rf_waddr;

    logic        req_ready2, wb_hold2, is_lhi2, is_lli2, rf_we2, busy2, done2;
    logic [7:0]  imm8_2;
    logic [2:0]  rf_rd_addr2, rf_waddr2;

    logic        pl_en;
    logic [2:0]  pl_addr;
    logic [15:0] pl_data;

    logic [15:0] rf  [8];
    logic [15:0] rf2 [8];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    li_sequencer #(.REG_AW(3), .MAX_STALL(4), .SKIP_ZERO_LO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_rt(req_rt), .req_imm16(req_imm16),
        .wb_busy(wb_busy), .wb_hold(wb_hold), .is_lhi(is_lhi), .is_lli(is_lli),
        .imm8(imm8), .rf_rd_addr(rf_rd_addr), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .busy(busy), .done(done)
    );

    li_sequencer #(.REG_AW(3), .MAX_STALL(4), .SKIP_ZERO_LO(1'b0)) dut_noskip (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
        .req_mode(req_mode), .req_rt(req_rt), .req_imm16(req_imm16),
        .wb_busy(wb_busy), .wb_hold(wb_hold2), .is_lhi(is_lhi2), .is_lli(is_lli2),
        .imm8(imm8_2), .rf_rd_addr(rf_rd_addr2), .rf_we(rf_we2), .rf_waddr(rf_waddr2),
        .busy(busy2), .done(done2)
    );

    // Register file plus helper: LHI yields {imm8,00}, LLI merges imm8 into old_rt.
    always @(posedge clk) begin
        if (pl_en) begin
            rf[pl_addr]  <= pl_data;
            rf2[pl_addr] <= pl_data;
        end else begin
            if (rf_we)
                rf[rf_waddr] <= is_lhi ? {imm8, 8'h00} : {rf[rf_rd_addr][15:8], imm8};
            if (rf_we2)
                rf2[rf_waddr2] <= is_lhi2 ? {imm8_2, 8'h00} : {rf2[rf_rd_addr2][15:8], imm8_2};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_mode = 2'b00; req_rt = '0;
        req_imm16 = '0; wb_busy = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        cyc(); cyc();
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        rst_n = 1'b1;
        #1;
        chk("idle_ready", req_ready, 1);
        chk("idle_imm8", imm8, 8'h00);
        chk("idle_hold", wb_hold, 0);

        // LI16 rt=3 imm=BEEF
        req_valid = 1'b1; req_mode = 2'b00; req_rt = 3'd3; req_imm16 = 16'hBEEF;
        #1;
        cyc(); req_valid = 1'b0; #1;
        chk("li16_hi_ctl", {rf_we, is_lhi, is_lli, busy}, 4'b1101);
        chk("li16_hi_imm8", imm8, 8'hBE);
        chk("li16_hi_waddr", rf_waddr, 3);
        cyc(); #1;
        chk("li16_rt_hi", rf[3], 16'hBE00);
        chk("li16_lo_ctl", {rf_we, is_lhi, is_lli}, 3'b101);
        chk("li16_lo_imm8", imm8, 8'hEF);
        chk("li16_lo_rdaddr", rf_rd_addr, 3);
        cyc(); #1;
        chk("li16_rt_final", rf[3], 16'hBEEF);
        chk("li16_done", {done, req_ready, busy}, 3'b110);

        // Preload r5, then LLI only rt=5 imm=0012
        pl_en = 1'b1; pl_addr = 3'd5; pl_data = 16'hAB34;
        cyc(); pl_en = 1'b0;
        chk("li16_done_pulse", done, 0);
        req_valid = 1'b1; req_mode = 2'b10; req_rt = 3'd5; req_imm16 = 16'h0012;
        #1;
        cyc(); req_valid = 1'b0; #1;
        chk("lli_ctl", {rf_we, is_lhi, is_lli}, 3'b101);
        chk("lli_imm8", imm8, 8'h12);
        chk("lli_rdaddr", rf_rd_addr, 5);
        cyc();
        chk("lli_rt", rf[5], 16'hAB12);
        chk("lli_done", {done, req_ready}, 2'b11);

        // LHI only, accepted in the done cycle
        req_valid = 1'b1; req_mode = 2'b01; req_rt = 3'd5; req_imm16 = 16'h7700;
        #1;
        cyc(); req_valid = 1'b0; #1;
        chk("lhi_ctl", {rf_we, is_lhi, is_lli}, 3'b110);
        chk("lhi_imm8", imm8, 8'h77);
        cyc();
        chk("lhi_rt", rf[5], 16'h7700);
        chk("lhi_done", done, 1);

        // LI16 with zero low byte: skip instance writes once, other writes twice
        req_valid = 1'b1; req_mode = 2'b00; req_rt = 3'd2; req_imm16 = 16'h1200;
        #1;
        cyc(); req_valid = 1'b0; #1;
        chk("skip_hi_we", {rf_we, is_lhi, rf_we2, is_lhi2}, 4'b1111);
        cyc(); #1;
        chk("skip_done", {done, rf_we, busy}, 3'b100);
        chk("skip_rt", rf[2], 16'h1200);
        chk("noskip_lo", {rf_we2, is_lli2, done2}, 3'b110);
        chk("noskip_imm8", imm8_2, 8'h00);
        cyc();
        chk("noskip_done", {done2, done}, 2'b10);
        chk("noskip_rt", rf2[2], 16'h1200);

        // Writeback stall during HI for 6 cycles
        req_valid = 1'b1; req_mode = 2'b00; req_rt = 3'd4; req_imm16 = 16'h5A5A;
        #1;
        cyc(); req_valid = 1'b0; wb_busy = 1'b1; #1;
        chk("stall1", {rf_we, is_lhi, wb_hold}, 3'b000);
        for (int i = 2; i <= 6; i++) begin
            cyc();
            chk($sformatf("stall%0d", i), {rf_we, is_lhi, wb_hold}, {2'b00, (i >= 5)});
        end
        cyc(); wb_busy = 1'b0; #1;
        chk("stall_write", {rf_we, is_lhi, wb_hold}, 3'b111);
        chk("stall_imm8", imm8, 8'h5A);
        cyc(); #1;
        chk("stall_lo", {rf_we, is_lli, wb_hold}, 3'b110);
        cyc();
        chk("stall_done", done, 1);
        chk("stall_rt", rf[4], 16'h5A5A);

        // Reset while in LO drops the request
        req_valid = 1'b1; req_mode = 2'b00; req_rt = 3'd6; req_imm16 = 16'h1234;
        #1;
        cyc(); req_valid = 1'b0; #1;
        chk("rstlo_hi", rf_we, 1);
        cyc(); rst_n = 1'b0; #1;
        chk("rstlo_quiet", {rf_we, is_lli, req_ready, wb_hold}, 4'b0000);
        cyc(); rst_n = 1'b1; #1;
        chk("rstlo_idle", {req_ready, busy, done}, 3'b100);
        chk("rstlo_rt", rf[6], 16'h1200);
        cyc();
        chk("rstlo_nodone", done, 0);

        // Fresh LI16 then a reserved request back-to-back in the done cycle
        req_valid = 1'b1; req_mode = 2'b00; req_rt = 3'd6; req_imm16 = 16'hCAFE;
        #1;
        cyc(); req_valid = 1'b0; #1;
        cyc();
        cyc();
        chk("b2b_rt", rf[6], 16'hCAFE);
        chk("b2b_done", {done, req_ready}, 2'b11);
        req_valid = 1'b1; req_mode = 2'b11; req_rt = 3'd1; req_imm16 = 16'hFFFF;
        #1;
        chk("rsv_accept_we", rf_we, 0);
        cyc(); req_valid = 1'b0; #1;
        chk("rsv_done", {done, rf_we, busy, req_ready}, 4'b1001);
        cyc(); #1;
        chk("rsv_after", {done, rf_we}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/li_sequencer.md
Name: li_sequencer

Overview:
- Sequences the LHI/LLI load-immediate helper and the register-file write port to run 16-bit constant loads (LI16), plus standalone LHI and LLI.
- An LI16 request becomes an LHI write followed by an LLI write to the same Rt.
- The register-file write port is shared with pipeline writeback, which always has priority. The sequencer waits for a free cycle and raises a starvation request if it waits too long.
- Sits between decode and the register file. It drives the helper's control inputs, read address and write enable.

Parameters:
- REG_AW, 3, register address width.
- MAX_STALL, 4, number of consecutive blocked write cycles before wb_hold is asserted.
- SKIP_ZERO_LO, 1, when 1 an LI16 whose low byte is 0x00 issues only the LHI write.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request this cycle.
- req_mode  in  2  00=LI16, 01=LHI only, 10=LLI only, 11=reserved (accepted, no write, done pulses).
- req_rt  in  REG_AW  destination register.
- req_imm16  in  16  immediate; LHI only uses [15:8], LLI only uses [7:0].
- wb_busy  in  1  pipeline writeback owns the write port this cycle.
- wb_hold  out  1  starvation request asking the pipeline to yield the write port.
- is_lhi  out  1  to helper: select LHI result.
- is_lli  out  1  to helper: select LLI result.
- imm8  out  8  to helper: immediate byte.
- rf_rd_addr  out  REG_AW  register-file read address whose data feeds the helper's old_rt.
- rf_we  out  1  register-file write enable; write data is the helper output.
- rf_waddr  out  REG_AW  write address.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse, registered, in the cycle after the last write of a request.

Behaviour:
- States: IDLE, HI, LO. The register file is written on the rising edge and read combinationally, so LO sees the value written in HI.
- Reset (rst_n=0 at an edge) sets state=IDLE, stall_cnt=0, done=0 and clears latched rt/imm/mode.
  - While rst_n=0, req_ready=0 and all write-side outputs are 0.
  - Reset mid-operation drops the request: no further writes and no done pulse.
- Outputs in IDLE: req_ready=1, rf_we=0, is_lhi=0, is_lli=0, imm8=0, wb_hold=0.
- Accept: req_valid && req_ready latches rt, imm16 and mode. Next state:
  - LI16 or LHI → HI.
  - LLI → LO.
  - Reserved → stay in IDLE, with done=1 next cycle.
- HI, when wb_busy=1:
  - rf_we=0, is_lhi=0; stall_cnt increments, saturating at MAX_STALL.
- HI, when wb_busy=0:
  - rf_we=1, is_lhi=1, imm8=imm[15:8], rf_waddr=rt; stall_cnt is cleared.
  - Next state is LO if mode=LI16 and not (SKIP_ZERO_LO && imm[7:0]==0).
  - Otherwise next state is IDLE and done=1 in the following cycle.
- LO:
  - rf_rd_addr=rt in all cycles of LO.
  - Stall rule is identical to HI.
  - On the write cycle: rf_we=1, is_lli=1, imm8=imm[7:0]; next state IDLE, done=1 next cycle.
- rf_rd_addr is the latched rt whenever state != IDLE; it is 0 in IDLE.
- wb_hold=1 while stall_cnt==MAX_STALL and state is HI or LO. It drops the cycle after the write issues.
- is_lhi and is_lli are never both 1. rf_we=1 only when wb_busy=0.
- Back-to-back: req_ready returns the cycle after the final write, the same cycle done=1. A new request may be accepted in that cycle.
- Per request: LI16 takes 2 write cycles plus stalls, or 1 when skipped. LHI and LLI take 1 each.

Test Plan:
- LI16, rt=3, imm=0xBEEF, wb_busy=0 → cycle+1: rf_we, is_lhi, imm8=0xBE, Rt=0xBE00. Cycle+2: is_lli, imm8=0xEF, Rt=0xBEEF. Cycle+3: done=1, req_ready=1.
- LLI only, rt=5, imm=0x0012, Rt preloaded 0xAB34 → one write, Rt=0xAB12. LHI only, imm=0x7700 → Rt=0x7700.
- LI16, imm=0x1200, SKIP_ZERO_LO=1 → single LHI write, Rt=0x1200, done 2 cycles after accept. With SKIP_ZERO_LO=0 → two writes, same final value.
- wb_busy held 1 for 6 cycles during HI, MAX_STALL=4 → rf_we=0 throughout, wb_hold=1 from the 5th blocked cycle, write on the first wb_busy=0 cycle, then wb_hold=0.
- rst_n=0 for one cycle while in LO → no LLI write, no done, IDLE with req_ready=1 after reset. A back-to-back LI16 accepted the cycle after done completes correctly.
- req_mode=11 → no rf_we ever, done pulse the cycle after accept.
